// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared state, enable encodings and saturation helper for the TMR datapath monitor
package tmr_pkg;

  typedef enum logic [1:0] {
    SIMPLEX = 2'd0,
    SETTLE  = 2'd1,
    TMR     = 2'd2
  } tmr_state_t;

  localparam logic [2:0] EN_TMR     = 3'b111;
  localparam logic [2:0] EN_SIMPLEX = 3'b001;
  localparam int         ERR_RATE_W = 4;

  function automatic logic [ERR_RATE_W-1:0] sat_inc(input logic [ERR_RATE_W-1:0] v,
                                                    input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/tmr_voter.sv
// rtl/tmr_voter.sv - combinational bitwise majority voter with per-replica disagree flags
module tmr_voter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] voted,
  output logic [2:0]       disagree,
  output logic             multi_err
);

  assign voted     = (r0 & r1) | (r1 & r2) | (r0 & r2);
  assign disagree  = {r2 != voted, r1 != voted, r0 != voted};
  // No pair agrees, so the majority word may match none of the replicas
  assign multi_err = (r0 != r1) && (r1 != r2) && (r0 != r2);

endmodule

// File: rtl/tmr_err_monitor.sv
// rtl/tmr_err_monitor.sv - TMR vote/pass-through with windowed error rate
// Optional per-replica fault localisation under TMR_FAULT_LOCATE_EN.
module tmr_err_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int WINDOW     = 64,
  parameter int SETTLE_CYC = 4
`ifdef TMR_FAULT_LOCATE_EN
  ,
  parameter int FAULT_TH   = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            en,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      r0,
  input  logic [WIDTH-1:0]      r1,
  input  logic [WIDTH-1:0]      r2,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  mismatch,
  output logic                  multi_err,
  output logic                  mode,
  output logic [ERR_RATE_W-1:0] err_rate,
  output logic [1:0]            fault_id
);

  localparam int SW = $clog2(WINDOW);
  localparam int CW = $clog2(SETTLE_CYC + 1);

  tmr_state_t      state, state_next;
  logic [CW-1:0]   settle_cnt, settle_next;
  logic [SW-1:0]   samp_cnt;
  logic [ERR_RATE_W-1:0] err_cnt, err_sum;

  logic [WIDTH-1:0] voted;
  logic [2:0]       disagree;
  logic             voter_multi;
  logic             in_tmr, err_event, multi_event, window_end;

  tmr_voter #(.WIDTH(WIDTH)) u_voter (
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .voted     (voted),
    .disagree  (disagree),
    .multi_err (voter_multi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SIMPLEX;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
    end
  end

  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    unique case (state)
      SIMPLEX: begin
        if (en == EN_TMR) begin
          state_next  = SETTLE;
          settle_next = CW'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        if (en != EN_TMR)
          state_next = SIMPLEX;
        else if (settle_cnt == '0)
          state_next = TMR;
        else
          settle_next = settle_cnt - 1'b1;
      end
      TMR: begin
        if (en != EN_TMR)
          state_next = SIMPLEX;
      end
      default: state_next = SIMPLEX;
    endcase
  end

  assign mode        = (state == TMR);
  assign in_tmr      = (state == TMR);
  assign err_event   = in_valid && in_tmr && (|disagree);
  assign multi_event = in_valid && in_tmr && voter_multi;
  assign window_end  = in_valid && (samp_cnt == SW'(WINDOW - 1));
  // The closing sample's own event is folded into the published rate
  assign err_sum     = sat_inc(err_cnt, err_event);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      mismatch  <= 1'b0;
      multi_err <= 1'b0;
      err_rate  <= '0;
      samp_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      out_valid <= in_valid;
      mismatch  <= err_event;
      multi_err <= multi_event;
      if (in_valid) begin
        out_data <= in_tmr ? voted : r0;
        if (window_end) begin
          err_rate <= err_sum;
          samp_cnt <= '0;
          err_cnt  <= '0;
        end else begin
          samp_cnt <= samp_cnt + 1'b1;
          err_cnt  <= err_sum;
        end
      end
    end
  end

`ifdef TMR_FAULT_LOCATE_EN
  logic [3:0] fcnt      [3];
  logic [3:0] fcnt_next [3];
  logic [1:0] fid_next;

  always_comb begin
    fid_next = 2'd0;
    for (int k = 0; k < 3; k++) begin
      fcnt_next[k] = fcnt[k];
      if (state_next != TMR)
        fcnt_next[k] = '0;
      else if (in_tmr && in_valid)
        fcnt_next[k] = disagree[k] ? sat_inc(fcnt[k], 1'b1)
                                   : ((fcnt[k] != '0) ? fcnt[k] - 1'b1 : '0);
    end
    // Descending scan so the lowest suspect index wins
    for (int k = 2; k >= 0; k--) begin
      if (fcnt_next[k] >= 4'(FAULT_TH))
        fid_next = 2'(k + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) fcnt[k] <= '0;
      fault_id <= 2'd0;
    end else begin
      for (int k = 0; k < 3; k++) fcnt[k] <= fcnt_next[k];
      fault_id <= fid_next;
    end
  end
`else
  assign fault_id = 2'd0;
`endif

endmodule

// File: tb/tb_tmr_err_monitor.sv
// tb/tb_tmr_err_monitor.sv - self-checking bench for tmr_err_monitor (vector table plus directed sequences)
module tb_tmr_err_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] en;
  logic       in_valid;
  logic [7:0] r0, r1, r2;
  logic       out_valid;
  logic [7:0] out_data;
  logic       mismatch;
  logic       multi_err;
  logic       mode;
  logic [3:0] err_rate;
  logic [1:0] fault_id;

  int checks = 0;
  int errors = 0;

  tmr_err_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .out_valid (out_valid),
    .out_data  (out_data),
    .mismatch  (mismatch),
    .multi_err (multi_err),
    .mode      (mode),
    .err_rate  (err_rate),
    .fault_id  (fault_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] en;
    logic       v;
    logic [7:0] a, b, c;
    logic       ov;
    logic [7:0] od;
    logic       mm, me, md;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] e, input logic v,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    en = e; in_valid = v; r0 = a; r1 = b; r2 = c;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 3'b001; in_valid = 1'b0; r0 = '0; r1 = '0; r2 = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic enter_tmr();
    for (int i = 0; i < 5; i++) drive(3'b111, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("enter_tmr_mode", 32'(mode), 32'd1);
  endtask

  initial begin
    tbl[0]  = '{3'b001, 1'b1, 8'h5A, 8'hFF, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{3'b111, 1'b1, 8'h5A, 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3'b111, 1'b1, 8'h5A, 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3'b111, 1'b1, 8'h5A, 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'b111, 1'b1, 8'h5A, 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{3'b111, 1'b1, 8'h5A, 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{3'b111, 1'b1, 8'h5A, 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{3'b111, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{3'b111, 1'b1, 8'h01, 8'h02, 8'h04, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{3'b111, 1'b1, 8'h3C, 8'h3C, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{3'b001, 1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{3'b001, 1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; en = 3'b111; in_valid = 1'b1; r0 = 8'h12; r1 = 8'h34; r2 = 8'h56;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_mismatch",  32'(mismatch),  32'd0);
    chk("rst_multi_err", 32'(multi_err), 32'd0);
    chk("rst_mode",      32'(mode),      32'd0);
    chk("rst_err_rate",  32'(err_rate),  32'd0);
    chk("rst_fault_id",  32'(fault_id),  32'd0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].en, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(tbl[i].od));
      chk($sformatf("vec%0d_mismatch", i),  32'(mismatch),  32'(tbl[i].mm));
      chk($sformatf("vec%0d_multi_err", i), 32'(multi_err), 32'(tbl[i].me));
      chk($sformatf("vec%0d_mode", i),      32'(mode),      32'(tbl[i].md));
      chk($sformatf("vec%0d_err_rate", i),  32'(err_rate),  32'd0);
    end

    // Simplex window with disagreeing replicas never counts
    do_reset();
    for (int i = 0; i < 64; i++) drive(3'b001, 1'b1, 8'h5A, 8'hFF, 8'h00);
    chk("simplex_out_data", 32'(out_data), 32'h5A);
    chk("simplex_mismatch", 32'(mismatch), 32'd0);
    chk("simplex_err_rate", 32'(err_rate), 32'd0);

    // Settle restarts after en drops mid-settle
    do_reset();
    drive(3'b111, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(3'b111, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(3'b001, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) drive(3'b111, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("settle_restart_mode_low", 32'(mode), 32'd0);
    drive(3'b111, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("settle_restart_mode_high", 32'(mode), 32'd1);

    // Saturation: 20 errors in one window, then a clean window
    do_reset();
    enter_tmr();
    for (int i = 0; i < 64; i++) begin
      drive(3'b111, 1'b1, 8'hA5, (i < 20) ? 8'h5A : 8'hA5, 8'hA5);
      if (i == 0)  chk("sat_out_data", 32'(out_data), 32'hA5);
      if (i == 62) chk("sat_err_rate_before_end", 32'(err_rate), 32'd0);
      if (i == 63) chk("sat_err_rate_end", 32'(err_rate), 32'd15);
    end
    for (int i = 0; i < 64; i++) begin
      drive(3'b111, 1'b1, 8'hA5, 8'hA5, 8'hA5);
      if (i == 62) chk("clean_err_rate_hold", 32'(err_rate), 32'd15);
    end
    chk("clean_err_rate_end", 32'(err_rate), 32'd0);

    // Sparse in_valid: 64 samples over 200 cycles, 5 errors incl. the closing sample
    do_reset();
    enter_tmr();
    begin
      int n;
      logic bad;
      n = 0;
      for (int i = 0; i < 200; i++) begin
        if ((i % 3 == 0) && (n < 64)) begin
          bad = (n == 3) || (n == 10) || (n == 20) || (n == 40) || (n == 63);
          drive(3'b111, 1'b1, 8'hC3, 8'hC3, bad ? 8'h00 : 8'hC3);
          n++;
          if (n == 63) chk("gap_err_rate_63", 32'(err_rate), 32'd0);
          if (n == 64) chk("gap_err_rate_64", 32'(err_rate), 32'd5);
        end else begin
          drive(3'b111, 1'b0, 8'h00, 8'h00, 8'h00);
          if (n == 64) chk("gap_out_valid_idle", 32'(out_valid), 32'd0);
        end
      end
      chk("gap_err_rate_hold", 32'(err_rate), 32'd5);
    end

    // Reset at sample 30 discards the partial window
    for (int i = 0; i < 30; i++) drive(3'b111, 1'b1, 8'hC3, 8'hC3, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_err_rate", 32'(err_rate), 32'd0);
    chk("midrst_mode", 32'(mode), 32'd0);
    enter_tmr();
    for (int i = 0; i < 64; i++) begin
      drive(3'b111, 1'b1, 8'hC3, 8'hC3, ((i == 5) || (i == 40)) ? 8'h00 : 8'hC3);
      if (i == 33) chk("midrst_no_early_end", 32'(err_rate), 32'd0);
    end
    chk("midrst_new_window", 32'(err_rate), 32'd2);

`ifdef TMR_FAULT_LOCATE_EN
    do_reset();
    enter_tmr();
    for (int i = 0; i < 8; i++) begin
      drive(3'b111, 1'b1, 8'h11, 8'h11, 8'hEE);
      if (i == 6) chk("fault_id_below_th", 32'(fault_id), 32'd0);
    end
    chk("fault_id_r2", 32'(fault_id), 32'd3);
    drive(3'b001, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("fault_id_clear", 32'(fault_id), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
